// File: rtl/mb_link_pkg.sv
// Shared types and frame-field widths for the motherboard MCU SPI frame link.
package mb_link_pkg;

  localparam int unsigned ALEX_W = 48;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned FCNT_W = 16;

  // 1 ms at 122.88 MHz with no completed frame declares the link dead
  localparam int unsigned DEF_TIMEOUT_CYCLES = 122880;
  localparam int unsigned DEF_ACK_FRAMES     = 8;

  typedef enum logic [1:0] {
    PK_IDLE    = 2'd0,
    PK_ARM     = 2'd1,
    PK_SENT    = 2'd2,
    PK_RELEASE = 2'd3
  } pk_state_e;

endpackage

// File: rtl/mb_load_sync.sv
// LOAD pin synchronizer with frame start/end detection and in-frame tracking.
module mb_load_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic load_i,
  output logic fs_o,
  output logic fe_valid_o,
  output logic in_frame_o
);

  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       fs_q, fe_q, in_frame_q;

  // Two-FF synchronizer, edge register and registered edge pulses (3 clocks pin to pulse).
  // A fall is only accepted once a real idle-high level has been seen, so a LOAD
  // held low through reset never opens a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      vld_q      <= 2'b00;
      armed_q    <= 1'b0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      sync1_q <= load_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & sync2_q);
      fs_q    <= armed_q & prev_q & ~sync2_q;
      fe_q    <= ~prev_q & sync2_q;
      if (fs_q) begin
        in_frame_q <= 1'b1;
      end else if (fe_q) begin
        in_frame_q <= 1'b0;
      end
    end
  end

  assign fs_o       = fs_q;
  assign fe_valid_o = fe_q & in_frame_q;
  assign in_frame_o = in_frame_q;

endmodule

// File: rtl/mb_spi_link_ctrl.sv
// FPGA-side sequencer for the MB MCU SPI frame link: frame-coherent commit of
// Alex/LED data, peak-detector clear handshake and link watchdog.
module mb_spi_link_ctrl
  import mb_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ACK_FRAMES     = DEF_ACK_FRAMES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              LOAD,
  input  logic              alex_wr,
  input  logic [ALEX_W-1:0] alex_wdata,
  input  logic [LED_W-1:0]  leds_in,
  input  logic              pk_req,
  input  logic              pk_detect_ack,
  output logic [ALEX_W-1:0] Alex_data,
  output logic              enable,
  output logic [LED_W-1:0]  leds,
  output logic              pk_detect_reset,
  output logic              pk_done,
  output logic              pk_fail,
  output logic              link_ok,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ACK_W = $clog2(ACK_FRAMES + 1);

  logic fs, fe_valid, in_frame;
  logic commit_c;

  logic [ALEX_W-1:0] stage_data_q;
  logic              stage_full_q;
  logic [ALEX_W-1:0] alex_data_q;
  logic              enable_q, en_started_q;
  logic [LED_W-1:0]  leds_q;
  logic [FCNT_W-1:0] frame_count_q;

  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              link_ok_q, link_ok_d;
  logic              link_fall_c;

  pk_state_e         pk_state_q;
  logic              pk_pend_q;
  logic [ACK_W-1:0]  ack_cnt_q;
  logic [ACK_W-1:0]  ack_cnt_nxt_c;
  logic              pk_reset_q, pk_done_q, pk_fail_q;

  mb_load_sync u_load_sync (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (LOAD),
    .fs_o       (fs),
    .fe_valid_o (fe_valid),
    .in_frame_o (in_frame)
  );

  // Commit only at a frame end or between frames, never on the frame-start cycle
  assign commit_c = fe_valid | (~in_frame & ~fs);

  // Staging register and frame-coherent commit of Alex word, enable flag and LEDs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_data_q  <= '0;
      stage_full_q  <= 1'b0;
      alex_data_q   <= '0;
      enable_q      <= 1'b0;
      en_started_q  <= 1'b0;
      leds_q        <= '0;
      frame_count_q <= '0;
    end else begin
      if (alex_wr) begin
        stage_data_q <= alex_wdata;
        stage_full_q <= 1'b1;
      end else if (commit_c && stage_full_q) begin
        stage_full_q <= 1'b0;
      end
      if (commit_c) begin
        leds_q <= leds_in;
        if (stage_full_q) begin
          alex_data_q <= stage_data_q;
        end
      end
      // enable flags exactly the first frame that starts after a commit
      if (commit_c && stage_full_q) begin
        enable_q     <= 1'b1;
        en_started_q <= 1'b0;
      end else if (fe_valid && en_started_q) begin
        enable_q     <= 1'b0;
        en_started_q <= 1'b0;
      end else if (fs && enable_q) begin
        en_started_q <= 1'b1;
      end
      if (fe_valid) begin
        frame_count_q <= frame_count_q + FCNT_W'(1);
      end
    end
  end

  // Watchdog next state: saturating idle counter and link status
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    link_ok_d = link_ok_q;
    if (fe_valid) begin
      wd_cnt_d  = '0;
      link_ok_d = 1'b1;
    end else begin
      if (wd_cnt_q != WD_W'(TIMEOUT_CYCLES)) begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
      if (wd_cnt_d == WD_W'(TIMEOUT_CYCLES)) begin
        link_ok_d = 1'b0;
      end
    end
  end

  assign link_fall_c = link_ok_q & ~link_ok_d;

  // Watchdog state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q  <= '0;
      link_ok_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      link_ok_q <= link_ok_d;
    end
  end

  // Frames seen since the request bit went out, including this cycle's frame end
  assign ack_cnt_nxt_c = ack_cnt_q + ACK_W'(fe_valid);

  // Peak-detector clear handshake; requests arriving while busy coalesce into pk_pend
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pk_state_q <= PK_IDLE;
      pk_pend_q  <= 1'b0;
      ack_cnt_q  <= '0;
      pk_reset_q <= 1'b0;
      pk_done_q  <= 1'b0;
      pk_fail_q  <= 1'b0;
    end else begin
      pk_done_q <= 1'b0;
      pk_fail_q <= 1'b0;
      if (pk_req && (pk_state_q != PK_IDLE)) begin
        pk_pend_q <= 1'b1;
      end
      if ((pk_state_q != PK_IDLE) && link_fall_c) begin
        pk_state_q <= PK_IDLE;
        pk_reset_q <= 1'b0;
        pk_fail_q  <= 1'b1;
      end else begin
        case (pk_state_q)
          PK_IDLE: begin
            if (pk_req || pk_pend_q) begin
              pk_state_q <= PK_ARM;
              pk_pend_q  <= 1'b0;
              pk_reset_q <= 1'b1;
            end
          end
          PK_ARM: begin
            if (fs) begin
              pk_state_q <= PK_SENT;
              ack_cnt_q  <= '0;
            end
          end
          PK_SENT: begin
            if (pk_detect_ack) begin
              pk_state_q <= PK_RELEASE;
              pk_reset_q <= 1'b0;
              ack_cnt_q  <= ack_cnt_nxt_c;
            end else if (fe_valid) begin
              if (ack_cnt_nxt_c == ACK_W'(ACK_FRAMES)) begin
                pk_state_q <= PK_IDLE;
                pk_reset_q <= 1'b0;
                pk_fail_q  <= 1'b1;
              end else begin
                ack_cnt_q <= ack_cnt_nxt_c;
              end
            end
          end
          PK_RELEASE: begin
            if (!pk_detect_ack) begin
              pk_state_q <= PK_IDLE;
              pk_done_q  <= 1'b1;
            end else if (fe_valid) begin
              if (ack_cnt_nxt_c == ACK_W'(ACK_FRAMES)) begin
                pk_state_q <= PK_IDLE;
                pk_fail_q  <= 1'b1;
              end else begin
                ack_cnt_q <= ack_cnt_nxt_c;
              end
            end
          end
          default: begin
            pk_state_q <= PK_IDLE;
            pk_reset_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Alex_data       = alex_data_q;
  assign enable          = enable_q;
  assign leds            = leds_q;
  assign frame_count     = frame_count_q;
  assign link_ok         = link_ok_q;
  assign pk_detect_reset = pk_reset_q;
  assign pk_done         = pk_done_q;
  assign pk_fail         = pk_fail_q;

endmodule

// File: tb/tb_mb_spi_link_ctrl.sv
// Directed plus randomized bench for mb_spi_link_ctrl against a frame-level model.
module tb_mb_spi_link_ctrl;

  localparam int unsigned TO  = 400;
  localparam int unsigned ACK = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        LOAD;
  logic        alex_wr;
  logic [47:0] alex_wdata;
  logic [7:0]  leds_in;
  logic        pk_req;
  logic        pk_detect_ack;
  logic [47:0] Alex_data;
  logic        enable;
  logic [7:0]  leds;
  logic        pk_detect_reset;
  logic        pk_done;
  logic        pk_fail;
  logic        link_ok;
  logic [15:0] frame_count;

  mb_spi_link_ctrl #(.TIMEOUT_CYCLES(TO), .ACK_FRAMES(ACK)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .LOAD            (LOAD),
    .alex_wr         (alex_wr),
    .alex_wdata      (alex_wdata),
    .leds_in         (leds_in),
    .pk_req          (pk_req),
    .pk_detect_ack   (pk_detect_ack),
    .Alex_data       (Alex_data),
    .enable          (enable),
    .leds            (leds),
    .pk_detect_reset (pk_detect_reset),
    .pk_done         (pk_done),
    .pk_fail         (pk_fail),
    .link_ok         (link_ok),
    .frame_count     (frame_count)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Frame-level reference model
  logic [47:0] exp_alex;
  logic        exp_en;
  logic        en_started;
  logic [7:0]  exp_leds;
  logic [15:0] exp_fcnt;
  logic        staged;
  logic [47:0] stage_word;
  logic        got_frame;
  int          fe_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    exp_alex   = '0;
    exp_en     = 1'b0;
    en_started = 1'b0;
    exp_leds   = '0;
    exp_fcnt   = '0;
    staged     = 1'b0;
    stage_word = '0;
    got_frame  = 1'b0;
    fe_cyc     = 0;
  endtask

  task automatic model_commit();
    if (staged) begin
      exp_alex   = stage_word;
      exp_en     = 1'b1;
      en_started = 1'b0;
      staged     = 1'b0;
    end
  endtask

  function automatic logic exp_link();
    return got_frame && ((cyc - fe_cyc) < int'(TO));
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".alex"}, 64'(Alex_data), 64'(exp_alex));
    check({tag, ".enable"}, 64'(enable), 64'(exp_en));
    check({tag, ".leds"}, 64'(leds), 64'(exp_leds));
    check({tag, ".fcnt"}, 64'(frame_count), 64'(exp_fcnt));
    check({tag, ".link"}, 64'(link_ok), 64'(exp_link()));
  endtask

  task automatic start_frame();
    LOAD = 1'b0;
    repeat (5) tick();
    if (exp_en) en_started = 1'b1;
    exp_leds = leds_in;
  endtask

  task automatic end_frame();
    LOAD = 1'b1;
    repeat (4) tick();
    exp_fcnt  = exp_fcnt + 16'd1;
    got_frame = 1'b1;
    fe_cyc    = cyc;
    if (en_started) begin
      exp_en     = 1'b0;
      en_started = 1'b0;
    end
    model_commit();
    exp_leds = leds_in;
  endtask

  task automatic write_word(input logic [47:0] w);
    alex_wr    = 1'b1;
    alex_wdata = w;
    tick();
    alex_wr    = 1'b0;
    staged     = 1'b1;
    stage_word = w;
  endtask

  logic [47:0] w;
  int          nw;

  initial begin
    reset_n       = 1'b0;
    LOAD          = 1'b0;
    alex_wr       = 1'b0;
    alex_wdata    = '0;
    leds_in       = 8'h00;
    pk_req        = 1'b0;
    pk_detect_ack = 1'b0;
    model_reset();
    repeat (3) tick();
    check_all("reset");
    check("reset.pk_rst", 64'(pk_detect_reset), 64'd0);
    check("reset.pk_done", 64'(pk_done), 64'd0);
    check("reset.pk_fail", 64'(pk_fail), 64'd0);

    // Partial first frame: LOAD low through reset must not count
    reset_n = 1'b1;
    repeat (5) tick();
    LOAD = 1'b1;
    repeat (6) tick();
    check("partial.fcnt", 64'(frame_count), 64'd0);
    check("partial.link", 64'(link_ok), 64'd0);

    // First full frame: counted 4 clocks after the rising pin edge
    LOAD = 1'b0;
    repeat (200) tick();
    LOAD = 1'b1;
    repeat (3) tick();
    check("first.fcnt_early", 64'(frame_count), 64'd0);
    check("first.link_early", 64'(link_ok), 64'd0);
    tick();
    exp_fcnt  = 16'd1;
    got_frame = 1'b1;
    fe_cyc    = cyc;
    check_all("first");
    repeat (3) tick();

    // Mid-frame Alex write commits only at frame end, flags one frame
    leds_in = 8'h3C;
    start_frame();
    write_word(48'h0000_1234_5678);
    leds_in = 8'hC3;
    repeat (3) tick();
    check("alex1.hold", 64'(Alex_data), 64'(exp_alex));
    check("alex1.leds_hold", 64'(leds), 64'h3C);
    end_frame();
    check("alex1.value", 64'(Alex_data), 64'h0000_1234_5678);
    check_all("alex1");
    start_frame();
    check("alex1.en_in_next", 64'(enable), 64'd1);
    end_frame();
    check("alex1.en_cleared", 64'(enable), 64'd0);
    check_all("alex1b");
    repeat (2) tick();

    // Two writes in one frame: last write wins
    start_frame();
    write_word(48'hAAAA_AAAA_AAAA);
    tick();
    write_word(48'h5555_5555_5555);
    end_frame();
    check("lastwins.value", 64'(Alex_data), 64'h5555_5555_5555);
    check_all("lastwins");
    start_frame();
    end_frame();
    check_all("lastwins_b");

    // Idle writes back to back: second word stages while the first commits
    alex_wr    = 1'b1;
    alex_wdata = 48'h0123_4567_89AB;
    tick();
    model_commit();
    staged = 1'b1; stage_word = 48'h0123_4567_89AB;
    alex_wdata = 48'hFEDC_BA98_7654;
    tick();
    model_commit();
    staged = 1'b1; stage_word = 48'hFEDC_BA98_7654;
    alex_wr = 1'b0;
    check("idle.first_commit", 64'(Alex_data), 64'h0123_4567_89AB);
    check("idle.first_en", 64'(enable), 64'd1);
    tick();
    model_commit();
    check("idle.second_commit", 64'(Alex_data), 64'hFEDC_BA98_7654);
    start_frame();
    end_frame();
    check_all("idle_b");

    // Peak handshake with a coalesced second request
    pk_req = 1'b1;
    tick();
    pk_req = 1'b0;
    check("pk.arm_rst", 64'(pk_detect_reset), 64'd1);
    start_frame();
    pk_req = 1'b1;
    tick();
    pk_req = 1'b1;
    tick();
    pk_req = 1'b0;
    end_frame();
    check("pk.sent_rst", 64'(pk_detect_reset), 64'd1);
    pk_detect_ack = 1'b1;
    tick();
    check("pk.release_rst", 64'(pk_detect_reset), 64'd0);
    check("pk.no_done_yet", 64'(pk_done), 64'd0);
    pk_detect_ack = 1'b0;
    tick();
    check("pk.done", 64'(pk_done), 64'd1);
    tick();
    check("pk.done_once", 64'(pk_done), 64'd0);
    check("pk.second_arm", 64'(pk_detect_reset), 64'd1);
    start_frame();
    end_frame();
    pk_detect_ack = 1'b1;
    tick();
    pk_detect_ack = 1'b0;
    tick();
    check("pk.second_done", 64'(pk_done), 64'd1);
    tick();
    check("pk.idle_rst", 64'(pk_detect_reset), 64'd0);

    // No ack for ACK frames: abort on the last valid frame end
    pk_req = 1'b1;
    tick();
    pk_req = 1'b0;
    for (int i = 1; i <= int'(ACK); i++) begin
      start_frame();
      end_frame();
      if (i < int'(ACK)) begin
        check("pkfail.no_fail_yet", 64'(pk_fail), 64'd0);
        check("pkfail.rst_held", 64'(pk_detect_reset), 64'd1);
      end else begin
        check("pkfail.fail", 64'(pk_fail), 64'd1);
        check("pkfail.rst_dropped", 64'(pk_detect_reset), 64'd0);
      end
    end
    tick();
    check("pkfail.pulse_once", 64'(pk_fail), 64'd0);

    // Link timeout while SENT aborts the handshake; next frame restores link
    pk_req = 1'b1;
    tick();
    pk_req = 1'b0;
    start_frame();
    end_frame();
    for (int i = 1; i <= int'(TO); i++) begin
      tick();
      if (i == int'(TO) - 1) begin
        check("wd.link_before", 64'(link_ok), 64'(exp_link()));
        check("wd.no_fail_before", 64'(pk_fail), 64'd0);
      end
    end
    check("wd.link_dropped", 64'(link_ok), 64'(exp_link()));
    check("wd.fail", 64'(pk_fail), 64'd1);
    check("wd.rst_dropped", 64'(pk_detect_reset), 64'd0);
    tick();
    check("wd.fail_once", 64'(pk_fail), 64'd0);
    start_frame();
    end_frame();
    check_all("wd.restore");

    // Randomized frames with 0..2 mid-frame writes and live LED changes
    for (int f = 0; f < 16; f++) begin
      leds_in = 8'($urandom);
      start_frame();
      nw = int'($urandom_range(0, 2));
      for (int k = 0; k < nw; k++) begin
        w = {16'($urandom), 32'($urandom)};
        write_word(w);
        repeat ($urandom_range(0, 3)) tick();
      end
      leds_in = 8'($urandom);
      repeat ($urandom_range(1, 20)) tick();
      check("rnd.leds_frozen", 64'(leds), 64'(exp_leds));
      check("rnd.alex_frozen", 64'(Alex_data), 64'(exp_alex));
      end_frame();
      check_all("rnd");
      repeat ($urandom_range(1, 8)) tick();
    end

    // Reset mid-frame discards the frame in flight and any staged word
    start_frame();
    write_word(48'hDEAD_BEEF_CAFE);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    check("midrst.pk_rst", 64'(pk_detect_reset), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    LOAD = 1'b1;
    repeat (6) tick();
    exp_leds = leds_in;
    check_all("midrst.after");
    start_frame();
    end_frame();
    check_all("midrst.frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
